// File: rtl/conv_mac_engine.sv
// Multi-cycle signed convolution MAC: LANES multipliers per cycle, bias, optional ReLU, saturation.
// Ports: clk, rst_n, in_valid/in_ready + data/weight/bias/relu_en in, out_valid/out_ready + result out, busy.
module conv_mac_engine #(
  parameter int BITWIDTH     = 8,
  parameter int DATACHANNEL  = 1,
  parameter int FILTERHEIGHT = 5,
  parameter int FILTERWIDTH  = 5,
  parameter int LANES        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0] data,
  input  logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0] weight,
  input  logic [BITWIDTH-1:0] bias,
  input  logic relu_en,
  output logic out_valid,
  input  logic out_ready,
  output logic [2*BITWIDTH-1:0] result,
  output logic busy
);

  localparam int N    = DATACHANNEL * FILTERHEIGHT * FILTERWIDTH;
  localparam int P    = (N + LANES - 1) / LANES;
  localparam int PW   = P * LANES;
  localparam int OW   = 2 * BITWIDTH;
  localparam int ACCW = OW + $clog2(N) + 1;
  localparam int CW   = (P > 1) ? $clog2(P) : 1;
  localparam int XW   = ACCW - OW;

  localparam logic [CW-1:0] LAST = CW'(P - 1);

  localparam logic signed [ACCW-1:0] SMAX =
    {{(XW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN =
    {{(XW + 1){1'b1}}, {(OW - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  // Window is padded to P*LANES elements and shifted down by LANES
  // elements per pass, so the lanes always read the bottom slots and
  // padding lanes see zeros.
  logic [BITWIDTH*PW-1:0] data_q;
  logic [BITWIDTH*PW-1:0] weight_q;
  logic [BITWIDTH-1:0]    bias_q;
  logic                   relu_q;
  logic signed [ACCW-1:0] acc;
  logic [CW-1:0]          pass;

  logic signed [ACCW-1:0]     lane_sum;
  logic signed [BITWIDTH-1:0] dl;
  logic signed [BITWIDTH-1:0] wl;
  logic signed [OW-1:0]       prod;

  always_comb begin
    lane_sum = '0;
    dl       = '0;
    wl       = '0;
    prod     = '0;
    for (int j = 0; j < LANES; j++) begin
      dl       = data_q[j*BITWIDTH +: BITWIDTH];
      wl       = weight_q[j*BITWIDTH +: BITWIDTH];
      prod     = dl * wl;
      lane_sum = lane_sum + {{XW{prod[OW-1]}}, prod};
    end
  end

  logic signed [ACCW-1:0] fin_val;
  logic [OW-1:0]          sat_val;

  always_comb begin
    fin_val = acc + {{(ACCW-BITWIDTH){bias_q[BITWIDTH-1]}}, bias_q};
    if (relu_q && fin_val[ACCW-1]) begin
      fin_val = '0;
    end
    if (fin_val > SMAX) begin
      sat_val = SMAX[OW-1:0];
    end else if (fin_val < SMIN) begin
      sat_val = SMIN[OW-1:0];
    end else begin
      sat_val = fin_val[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      weight_q  <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      acc       <= '0;
      pass      <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= (BITWIDTH*PW)'(data);
            weight_q <= (BITWIDTH*PW)'(weight);
            bias_q   <= bias;
            relu_q   <= relu_en;
            acc      <= '0;
            pass     <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc      <= acc + lane_sum;
          data_q   <= data_q >> (BITWIDTH * LANES);
          weight_q <= weight_q >> (BITWIDTH * LANES);
          pass     <= pass + 1'b1;
          if (pass == LAST) begin
            state <= FIN;
          end
        end
        FIN: begin
          result    <= sat_val;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == MAC) || (state == DONE);

endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomized self-checking bench for conv_mac_engine (LANES=5 and LANES=7).
// Compares against a plain-arithmetic dot-product/ReLU/saturation model.
module tb_conv_mac_engine;

  localparam int N = 25;

  logic clk = 1'b0;
  logic rst_n;
  logic [8*N-1:0] data;
  logic [8*N-1:0] weight;
  logic [7:0] bias;
  logic relu_en;

  logic in_valid5, in_ready5, out_valid5, out_ready5, busy5;
  logic [15:0] result5;
  logic in_valid7, in_ready7, out_valid7, out_ready7, busy7;
  logic [15:0] result7;

  bit sel;
  logic ir, ov, bz;
  logic [15:0] rs;

  int n_tests = 0;
  int n_fail  = 0;
  int d[N];
  int w[N];

  always #5 clk = ~clk;

  conv_mac_engine #(.LANES(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid5), .in_ready(in_ready5),
    .data(data), .weight(weight), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid5), .out_ready(out_ready5),
    .result(result5), .busy(busy5)
  );

  conv_mac_engine #(.LANES(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid7), .in_ready(in_ready7),
    .data(data), .weight(weight), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid7), .out_ready(out_ready7),
    .result(result7), .busy(busy7)
  );

  assign ir = sel ? in_ready7  : in_ready5;
  assign ov = sel ? out_valid7 : out_valid5;
  assign bz = sel ? busy7      : busy5;
  assign rs = sel ? result7    : result5;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int b, input bit r);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(d[i] * w[i]);
    s += b;
    if (r && s < 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic set_valid(input bit v);
    if (sel) in_valid7 = v; else in_valid5 = v;
  endtask

  task automatic set_ready(input bit v);
    if (sel) out_ready7 = v; else out_ready5 = v;
  endtask

  task automatic load(input int b, input bit r);
    for (int i = 0; i < N; i++) begin
      data[i*8 +: 8]   = 8'(d[i]);
      weight[i*8 +: 8] = 8'(w[i]);
    end
    bias    = 8'(b);
    relu_en = r;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      data[i*8 +: 8]   = 8'($urandom);
      weight[i*8 +: 8] = 8'($urandom);
    end
    bias    = 8'($urandom);
    relu_en = ~relu_en;
  endtask

  task automatic rand_window();
    for (int i = 0; i < N; i++) begin
      d[i] = int'($urandom_range(0, 255)) - 128;
      w[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!ov && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  // Called #1 after a clock edge.
  task automatic run(input string tag, input int b, input bit r, input int lat);
    longint expv;
    int cnt;
    expv = model(b, r);
    load(b, r);
    set_valid(1'b1);
    cnt = 0;
    while (!ir && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    @(posedge clk); #1;
    set_valid(1'b0);
    scramble();
    check({tag, "_busy"}, longint'({ir, bz}), 64'd1);
    wait_out(cnt);
    check({tag, "_lat"}, cnt, lat);
    check({tag, "_res"}, longint'($signed(rs)), expv);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    check({tag, "_hs"}, longint'({ov, ir}), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    longint expv;
    logic [15:0] held;
    bit ok_v, ok_r, ok_i;
    int cnt;

    sel = 1'b0;
    rst_n = 1'b0;
    data = '0;
    weight = '0;
    bias = '0;
    relu_en = 1'b0;
    in_valid5 = 1'b0;
    in_valid7 = 1'b0;
    out_ready5 = 1'b0;
    out_ready7 = 1'b0;
    #17;
    check("rst_ready", in_ready5, 1);
    check("rst_valid", out_valid5, 0);
    check("rst_busy", busy5, 0);
    check("rst_result", result5, 0);
    check("rst_ready7", in_ready7, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) begin d[i] = 1; w[i] = 1; end
    run("ones", 0, 1'b0, 6);
    for (int i = 0; i < N; i++) begin d[i] = -1; w[i] = 2; end
    run("neg", 3, 1'b0, 6);
    run("neg_relu", 3, 1'b1, 6);
    for (int i = 0; i < N; i++) begin d[i] = 127; w[i] = 127; end
    run("sat_pos", 127, 1'b0, 6);
    for (int i = 0; i < N; i++) begin d[i] = -128; w[i] = 127; end
    run("sat_neg", -128, 1'b0, 6);

    for (int k = 0; k < 15; k++) begin
      rand_window();
      run($sformatf("rnd5_%0d", k), int'($urandom_range(0, 255)) - 128,
          1'($urandom), 6);
    end

    // Backpressure: in_valid stays high with new data throughout.
    rand_window();
    expv = model(10, 1'b0);
    load(10, 1'b0);
    set_valid(1'b1);
    check("bp_idle", ir, 1);
    @(posedge clk); #1;
    scramble();
    wait_out(cnt);
    check("bp_lat", cnt, 6);
    check("bp_res", longint'($signed(rs)), expv);
    held = rs;
    ok_v = 1'b1; ok_r = 1'b1; ok_i = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov !== 1'b1) ok_v = 1'b0;
      if (rs !== held) ok_r = 1'b0;
      if (ir !== 1'b0) ok_i = 1'b0;
    end
    check("bp_hold_valid", ok_v, 1);
    check("bp_hold_result", ok_r, 1);
    check("bp_no_accept", ok_i, 1);
    set_valid(1'b0);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    check("bp_hs", longint'({ov, ir}), 64'd1);
    @(posedge clk); #1;
    check("bp_idle_after", longint'({ir, bz}), 64'd2);

    // Reset during the third MAC pass.
    rand_window();
    load(1, 1'b0);
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst", longint'({ov, rs, bz, ir}), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", ir, 1);
    for (int i = 0; i < N; i++) begin d[i] = 2; w[i] = 3; end
    run("after_rst", -5, 1'b0, 6);

    sel = 1'b1;
    for (int i = 0; i < N; i++) begin d[i] = i - 12; w[i] = 1; end
    run("l7_zero", 0, 1'b0, 5);
    for (int i = 0; i < N; i++) begin d[i] = i - 12; w[i] = i; end
    run("l7_sq", 0, 1'b0, 5);
    for (int k = 0; k < 8; k++) begin
      rand_window();
      run($sformatf("rnd7_%0d", k), int'($urandom_range(0, 255)) - 128,
          1'($urandom), 5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Sequential, lane-parametrised successor to the single-shot combinational convolution kernel. It accepts one full convolution window of data, weights and bias via a valid/ready handshake, then evaluates the signed dot product over several cycles using LANES parallel multipliers. It adds the bias, optionally applies ReLU, and saturates the result to 2*BITWIDTH. It sits between the LeNet window/line-buffer logic and the feature-map writeback, and trades multiplier area against latency.

## Interface
- BITWIDTH, 8, width of each signed data/weight/bias element
- DATACHANNEL, 1, input channels per window
- FILTERHEIGHT, 5, kernel rows
- FILTERWIDTH, 5, kernel columns
- LANES, 5, multipliers used per MAC cycle (1..N, where N = DATACHANNEL*FILTERHEIGHT*FILTERWIDTH)
- clk  in  1  the single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  window, weight, bias and relu_en are valid
- in_ready  out  1  engine can accept a window
- data  in  BITWIDTH*N  window elements, element i at bits [(i+1)*BITWIDTH-1 : i*BITWIDTH]
- weight  in  BITWIDTH*N  kernel elements, same packing as data
- bias  in  BITWIDTH  signed bias
- relu_en  in  1  clamp negative results to 0
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts the result
- result  out  2*BITWIDTH  signed, saturated result
- busy  out  1  high in MAC or DONE

## Operation
- Arithmetic is signed two's complement throughout. Products are 2*BITWIDTH wide.
- The internal accumulator is ACCW = 2*BITWIDTH + clog2(N) + 1 bits wide, so it cannot overflow.
- Passes: P = ceil(N/LANES). In pass k, lane j handles element k*LANES+j. Lanes with an index >= N contribute 0.
- States:
  - IDLE: in_ready=1. When in_valid is high, capture data, weight, bias and relu_en into internal registers, clear the accumulator and pass counter, then go to MAC.
  - MAC: each cycle, add the sum of the LANES products to the accumulator and increment the pass counter. After pass P-1, go to FIN.
  - FIN: compute the final value as accumulator + sign-extended bias. If relu_en was captured high and the value is negative, set it to 0. Saturate the value to [-2^(2*BITWIDTH-1), 2^(2*BITWIDTH-1)-1], register it into result, set out_valid=1, and go to DONE.
  - DONE: hold result and out_valid stable. When out_ready is high, clear out_valid and go to IDLE.
- Input changes after capture have no effect on the result in flight.
- There is no overlap between windows: in_ready is 0 in MAC, FIN and DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, accumulator=0, pass counter=0.
- An asserted rst_n mid-operation aborts the window. No output is produced, and after release the engine is in IDLE with in_ready=1.

## Timing
- Let edge T be the accept edge (in_valid & in_ready). MAC passes occur at edges T+1..T+P, the FIN register update occurs at edge T+P+1, and out_valid is visible from that edge onward.
- Latency from accept edge to out_valid is P+1 cycles; for the default configuration this is 6.
- Output handshake completes at the edge where out_valid & out_ready. in_ready is 1 in the following cycle.
- Minimum accept-to-accept interval is P+3 cycles with out_ready tied high.
- in_ready and busy are decoded from the state register (registered), with no combinational path from in_valid or out_ready.
- out_valid, once high, stays high and result holds until the handshake completes, regardless of out_ready.

## Test plan
- Defaults, all data=1, weight=1, bias=0, relu_en=0 -> result=25, out_valid rises 6 cycles after the accept edge.
- All data=-1, weight=2, bias=3, relu_en=0 -> result=-47. The same inputs with relu_en=1 -> result=0.
- Saturation: data=127, weight=127, bias=127 -> +32767. data=-128, weight=127, bias=-128 -> -32768.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stay stable, in_ready=0, and a new in_valid is not accepted. Then pulse out_ready -> in_ready=1 the next cycle.
- Reset mid-MAC: assert rst_n=0 during pass 3 -> out_valid=0 and result=0 immediately. After release, in_ready=1, and a new window data=2, weight=3, bias=-5 -> 145.
- LANES=7 (non-divisor, P=4) with data[i]=i-12, weight[i]=1, bias=0 -> result=0, latency 5. Also run with weight[i]=i, giving sum over i of (i-12)*i = 1300 -> result=1300.
